// File: rtl/beta_alu_pkg.sv
// -----------------------------------------------------------------------------
// beta_alu_pkg
// Shared definitions for the Beta ALU scheduler slice:
//   - ALUFN opcode constants (Beta encoding)
//   - scheduler FSM state encoding
//   - default operand and opcode widths
// No ports; imported by beta_rr_arbiter and beta_alu_sched.
// -----------------------------------------------------------------------------
package beta_alu_pkg;

   localparam int W_DEF   = 32;
   localparam int OPW_DEF = 6;

   // ALUFN opcodes
   localparam logic [5:0] ALUFN_ADD   = 6'b100000;
   localparam logic [5:0] ALUFN_SUB   = 6'b100001;
   localparam logic [5:0] ALUFN_AND   = 6'b101000;
   localparam logic [5:0] ALUFN_OR    = 6'b101110;
   localparam logic [5:0] ALUFN_XOR   = 6'b100110;
   localparam logic [5:0] ALUFN_CMPEQ = 6'b110011;
   localparam logic [5:0] ALUFN_CMPLT = 6'b110101;
   localparam logic [5:0] ALUFN_SHL   = 6'b111000;
   localparam logic [5:0] ALUFN_SHR   = 6'b111001;
   localparam logic [5:0] ALUFN_SRA   = 6'b111011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/beta_rr_arbiter.sv
// -----------------------------------------------------------------------------
// beta_rr_arbiter
// Purely combinational round-robin pick: the first asserted request at or
// after ptr, wrapping NREQ-1 -> 0. The pointer register lives in the caller.
// Ports:
//   req      in   NREQ  request vector
//   ptr      in   IDW   highest-priority index
//   gnt      out  NREQ  one-hot grant (all zero when no request)
//   gnt_idx  out  IDW   encoded grant index
//   gnt_any  out  1     at least one request present
// -----------------------------------------------------------------------------
module beta_rr_arbiter
   import beta_alu_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_idx,
   output logic            gnt_any
);

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_any && req[(int'(ptr) + k) % NREQ]) begin
            gnt_any                        = 1'b1;
            gnt[(int'(ptr) + k) % NREQ]    = 1'b1;
            gnt_idx                        = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

endmodule

// File: rtl/beta_alu_sched.sv
// -----------------------------------------------------------------------------
// beta_alu_sched
// Shares one beta_alu between NREQ requesters with round-robin arbitration and
// a single op outstanding: grant -> issue -> wait for alu_done -> respond.
// A WAIT that lasts TIMEOUT cycles without alu_done aborts with rsp_err=1.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. valid never depends on ready; once rsp_valid is up, rsp_id/y/err
// hold until the transfer. req_ready is a combinational, at-most-one-hot
// grant that only appears in IDLE.
//
// Optional feature: define BETA_ALU_SCHED_STATS_EN to build the busy_cnt
// counter (cycles in ISSUE or WAIT, saturating); otherwise busy_cnt is 0.
//
// Ports:
//   clk, reset (async, active-low)
//   req_valid/req_ready/req_op/req_a/req_b : packed per-requester op inputs
//   alu_start/alu_op/alu_a/alu_b           : op issue to the ALU
//   alu_done/alu_y                         : ALU completion
//   rsp_valid/rsp_ready/rsp_id/rsp_y/rsp_err : result channel
//   busy_cnt                               : ALU-busy cycle counter
//   dbg_state                              : current FSM state
// -----------------------------------------------------------------------------
module beta_alu_sched
   import beta_alu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = W_DEF,
   parameter int OPW     = OPW_DEF,
   parameter int IDW     = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*OPW-1:0] req_op,
   input  logic [NREQ*W-1:0]   req_a,
   input  logic [NREQ*W-1:0]   req_b,
   output logic                alu_start,
   output logic [OPW-1:0]      alu_op,
   output logic [W-1:0]        alu_a,
   output logic [W-1:0]        alu_b,
   input  logic                alu_done,
   input  logic [W-1:0]        alu_y,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [W-1:0]        rsp_y,
   output logic                rsp_err,
   output logic [31:0]         busy_cnt,
   output logic [1:0]          dbg_state
);

   sched_state_t    state, state_nxt;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  cap_id;
   logic [7:0]      wait_cnt;
   logic [NREQ-1:0] arb_gnt;
   logic [IDW-1:0]  arb_idx;
   logic            arb_any;
   logic            grant;
   logic            timed_out;

   beta_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (req_valid),
      .ptr     (ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_any (arb_any)
   );

   assign grant     = (state == ST_IDLE) && arb_any;
   // wait_cnt holds the number of WAIT cycles already completed, so this is
   // the TIMEOUT-th WAIT cycle; alu_done in the same cycle takes priority.
   assign timed_out = (wait_cnt == 8'(TIMEOUT - 1));
   assign dbg_state = state;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (arb_any)               state_nxt = ST_ISSUE;
         ST_ISSUE:                            state_nxt = ST_WAIT;
         ST_WAIT:  if (alu_done || timed_out) state_nxt = ST_RESP;
         ST_RESP:  if (rsp_ready)             state_nxt = ST_IDLE;
         default:                             state_nxt = ST_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      req_ready = '0;
      alu_start = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         ST_IDLE:  req_ready = arb_gnt;
         ST_ISSUE: alu_start = 1'b1;
         ST_RESP:  rsp_valid = 1'b1;
         default:  ;
      endcase
   end

   // Datapath: captured op, round-robin pointer, wait counter, response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr      <= '0;
         cap_id   <= '0;
         alu_op   <= '0;
         alu_a    <= '0;
         alu_b    <= '0;
         wait_cnt <= '0;
         rsp_id   <= '0;
         rsp_y    <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (grant) begin
            ptr    <= (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
            cap_id <= arb_idx;
            alu_op <= req_op[arb_idx*OPW +: OPW];
            alu_a  <= req_a[arb_idx*W +: W];
            alu_b  <= req_b[arb_idx*W +: W];
         end
         if (state == ST_ISSUE)     wait_cnt <= '0;
         else if (state == ST_WAIT) wait_cnt <= wait_cnt + 8'd1;
         if (state == ST_WAIT) begin
            if (alu_done) begin
               rsp_id  <= cap_id;
               rsp_y   <= alu_y;
               rsp_err <= 1'b0;
            end else if (timed_out) begin
               rsp_id  <= cap_id;
               rsp_y   <= '0;
               rsp_err <= 1'b1;
            end
         end
      end
   end

`ifdef BETA_ALU_SCHED_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt <= '0;
      end else if (((state == ST_ISSUE) || (state == ST_WAIT)) && (busy_cnt != 32'hFFFF_FFFF)) begin
         busy_cnt <= busy_cnt + 32'd1;
      end
   end
`else
   assign busy_cnt = '0;
`endif

endmodule

// File: tb/tb_beta_alu_sched.sv
module tb_beta_alu_sched;
   import beta_alu_pkg::*;

   localparam int NREQ    = 4;
   localparam int W       = 32;
   localparam int OPW     = 6;
   localparam int IDW     = 2;
   localparam int TIMEOUT = 64;
   localparam int EW      = 1 + IDW + W;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*OPW-1:0] req_op;
   logic [NREQ*W-1:0]   req_a;
   logic [NREQ*W-1:0]   req_b;
   logic                alu_start;
   logic [OPW-1:0]      alu_op;
   logic [W-1:0]        alu_a;
   logic [W-1:0]        alu_b;
   logic                alu_done;
   logic [W-1:0]        alu_y;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [W-1:0]        rsp_y;
   logic                rsp_err;
   logic [31:0]         busy_cnt;
   logic [1:0]          dbg_state;

   logic                model_done = 1'b0;
   logic                extra_done = 1'b0;
   logic [W-1:0]        model_y = '0;
   int                  alu_lat = 2;
   bit                  alu_hang = 1'b0;

   logic [EW-1:0]       exp_q[$];
   int                  gnt_log[$];
   int                  n_checks = 0;
   int                  n_pass = 0;
   int                  start_cnt = 0;
   bit                  prev_gnt = 1'b0;
   logic [IDW-1:0]      last_id = '0;
   logic [W-1:0]        last_y = '0;
   logic                last_err = 1'b0;

   assign alu_done = model_done | extra_done;
   assign alu_y    = model_y;

   beta_alu_sched #(.NREQ(NREQ), .W(W), .OPW(OPW), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .alu_start (alu_start),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_done  (alu_done),
      .alu_y     (alu_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .busy_cnt  (busy_cnt),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [W-1:0] alu_fn(input logic [OPW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      case (op)
         ALUFN_ADD: return a + b;
         ALUFN_SUB: return a - b;
         ALUFN_AND: return a & b;
         ALUFN_OR:  return a | b;
         ALUFN_XOR: return a ^ b;
         default:   return '0;
      endcase
   endfunction

   // ---------------- ALU model ----------------
   // alu_done is raised alu_lat cycles after the alu_start cycle (lat=1 means
   // done in the first WAIT cycle).
   initial begin
      forever begin
         @(negedge clk);
         if (reset && alu_start && !alu_hang) begin
            model_y = alu_fn(alu_op, alu_a, alu_b);
            repeat (alu_lat) @(negedge clk);
            model_done = 1'b1;
            @(negedge clk);
            model_done = 1'b0;
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : mon
      int            g;
      logic          e_err;
      logic [W-1:0]  e_y;
      logic [EW-1:0] e;
      if (reset) begin
         if (alu_start) start_cnt++;
         if (prev_gnt) check("ready_pulse", req_ready, 0);
         prev_gnt = 1'b0;
         if (|req_ready) begin
            g = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (req_ready[i]) g = i;
            check("gnt_onehot", $onehot(req_ready), 1);
            check("gnt_valid", req_valid[g], 1);
            gnt_log.push_back(g);
            e_err = alu_hang || (alu_lat > TIMEOUT);
            e_y   = e_err ? '0 : alu_fn(req_op[g*OPW +: OPW], req_a[g*W +: W], req_b[g*W +: W]);
            exp_q.push_back({e_err, IDW'(g), e_y});
            prev_gnt = 1'b1;
         end
         if (rsp_valid && rsp_ready) begin
            last_id  = rsp_id;
            last_y   = rsp_y;
            last_err = rsp_err;
            if (exp_q.size() == 0) begin
               check("rsp_unexp", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_id", rsp_id, e[W +: IDW]);
               check("rsp_y", rsp_y, e[W-1:0]);
               check("rsp_err", rsp_err, e[EW-1]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input int id, input logic [OPW-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b);
      req_op[id*OPW +: OPW] = op;
      req_a[id*W +: W]      = a;
      req_b[id*W +: W]      = b;
      req_valid[id]         = 1'b1;
   endtask

   task automatic wait_grant(input int id, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[id]) ok = 1'b1;
      end
      check(tag, ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic wait_rsp(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) ok = 1'b1;
      end
      check(tag, ok, 1);
      @(posedge clk); #1;
   endtask

   task automatic do_op(input int id, input logic [OPW-1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int lat);
      alu_lat = lat;
      drive_req(id, op, a, b);
      wait_grant(id, "op_grant");
      req_valid[id] = 1'b0;
      wait_rsp("op_rsp");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [OPW-1:0] ops [NREQ];
      int             cnt;
      bit             seen;
      ops = '{ALUFN_ADD, ALUFN_SUB, ALUFN_AND, ALUFN_XOR};
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;

      // reset values
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", dbg_state, ST_IDLE);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_alu_start", alu_start, 0);
      check("rst_rsp_y", rsp_y, 0);
      check("rst_busy", busy_cnt, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // round-robin with all requesters continuously valid
      alu_lat = 1;
      gnt_log.delete();
      for (int i = 0; i < NREQ; i++) drive_req(i, ops[i], $urandom, $urandom_range(1000, 0));
      for (int i = 0; i < 400 && gnt_log.size() < 5; i++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      check("rr_count", gnt_log.size() >= 5, 1);
      if (gnt_log.size() >= 5)
         for (int i = 0; i < 5; i++) check("rr_order", gnt_log[i], i % NREQ);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      @(posedge clk); #1;
      check("rr_drain", exp_q.size(), 0);

      // single op
      start_cnt = 0;
      do_op(0, ALUFN_ADD, 5, 7, 2);
      check("t1_starts", start_cnt, 1);
      check("t1_id", last_id, 0);
      check("t1_y", last_y, 12);
      check("t1_err", last_err, 0);

      // backpressure: response held 5 cycles, another requester waiting
      rsp_ready = 1'b0;
      alu_lat = 2;
      drive_req(2, ALUFN_SUB, 100, 30);
      wait_grant(2, "t3_grant");
      req_valid[2] = 1'b0;
      drive_req(3, ALUFN_XOR, 32'hF0F0, 32'h0FF0);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      check("t3_rsp_seen", seen, 1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("t3_hold_valid", rsp_valid, 1);
         check("t3_hold_id", rsp_id, 2);
         check("t3_hold_y", rsp_y, 70);
         check("t3_no_grant", req_ready, 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      wait_grant(3, "t3_next_grant");
      req_valid[3] = 1'b0;
      wait_rsp("t3_next_rsp");
      check("t3_next_y", last_y, 32'hFF00);

      // timeout: ALU never answers
      alu_hang = 1'b1;
      drive_req(1, ALUFN_AND, 32'hFFFF, 32'h1234);
      wait_grant(1, "t4_grant");
      req_valid[1] = 1'b0;
      @(negedge clk);
      check("t4_start", alu_start, 1);
      cnt = 0;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         cnt++;
         seen = rsp_valid;
      end
      check("t4_lat", cnt, TIMEOUT + 1);
      check("t4_err", rsp_err, 1);
      check("t4_y", rsp_y, 0);
      @(posedge clk); #1;
      alu_hang = 1'b0;
      do_op(1, ALUFN_ADD, 1, 2, 1);
      check("t4_after_y", last_y, 3);
      check("t4_after_err", last_err, 0);

      // done on the last allowed WAIT cycle wins; one cycle later is a timeout
      do_op(2, ALUFN_OR, 32'h00F0, 32'h0F00, TIMEOUT);
      check("edge_done_err", last_err, 0);
      check("edge_done_y", last_y, 32'h0FF0);
      do_op(3, ALUFN_ADD, 10, 20, TIMEOUT + 1);
      check("edge_late_err", last_err, 1);
      check("edge_late_y", last_y, 0);

      // async reset while waiting
      alu_hang = 1'b1;
      drive_req(0, ALUFN_SUB, 9, 4);
      wait_grant(0, "t5_grant");
      req_valid[0] = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_in_wait", dbg_state, ST_WAIT);
      #2 reset = 1'b0;
      #1;
      check("t5_state", dbg_state, ST_IDLE);
      check("t5_rsp_valid", rsp_valid, 0);
      check("t5_alu_start", alu_start, 0);
      check("t5_alu_op", alu_op, 0);
      check("t5_alu_a", alu_a, 0);
      check("t5_alu_b", alu_b, 0);
      check("t5_rsp_y", rsp_y, 0);
      check("t5_rsp_err", rsp_err, 0);
      check("t5_req_ready", req_ready, 0);
      check("t5_busy", busy_cnt, 0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      alu_hang = 1'b0;
      @(negedge clk);
      extra_done = 1'b1;
      @(negedge clk);
      extra_done = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      check("t5_no_rsp", seen, 0);
      check("t5_idle", dbg_state, ST_IDLE);
      @(posedge clk); #1;

      // busy counter over three 2-cycle-latency ops since reset
      for (int i = 0; i < 3; i++) do_op(i, ALUFN_ADD, $urandom_range(500, 0), 3, 2);
`ifdef BETA_ALU_SCHED_STATS_EN
      check("busy_cnt", busy_cnt, 9);
`else
      check("busy_cnt", busy_cnt, 0);
`endif

      repeat (3) @(posedge clk);
      check("final_drain", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
